// File: rtl/zxnet_bus_bridge.sv
// zxnet_bus_bridge
// Glue logic between a ZX-Spectrum Z80 bus and two peripherals: a W5300
// Ethernet controller and an SL811 USB host.
//
// Ports:
//   clk, rst            : Z80 clock, asynchronous active-high reset
//   za, zd              : Z80 address / bidirectional data
//   ziorq_n, zmreq_n,
//   zrd_n, zwr_n        : Z80 strobes
//   zcsrom_n            : host ROM chip select
//   ziorqge             : this block owns the current I/O cycle
//   zblkrom             : block the host ROM (W5300 memory window active)
//   zint_n              : open-drain interrupt request (0 or Z)
//   bd, brd_n, bwr_n    : peripheral data bus and read/write strobes
//   w5300_*             : W5300 reset, address, select, interrupt input
//   sl811_*             : SL811 reset, a0, select, master/slave, interrupt
//   usb_power           : USB VBUS sense
//
// I/O ports (low byte 0xAB):
//   0x83 RSTINT : {irq_any, eintena, sl_rst, w_rst, sl_ie, w_ie, sl_irq, w_irq}
//   0x82 W5300  : {addr_hi[2:0], port_mode, a0_inv, map_en, win[1:0]}
//   0x81 SL811  : write {.., ms}; read {6'b0, usb_power, ms}
//   0x80        : SL811 register access, a0 = 0
//   za[15] = 0  : data port (SL811 a0 = 1, or W5300 in port mode)
module zxnet_bus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  inout  wire  [7:0]  zd,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  output logic        ziorqge,
  output logic        zblkrom,
  output wire         zint_n,
  inout  wire  [7:0]  bd,
  output logic        brd_n,
  output logic        bwr_n,
  output logic        w5300_rst_n,
  output logic [9:0]  w5300_addr,
  output logic        w5300_cs_n,
  input  logic        w5300_int_n,
  output logic        sl811_rst_n,
  output logic        sl811_a0,
  output logic        sl811_cs_n,
  output logic        sl811_ms_n,
  input  logic        sl811_intrq,
  input  logic        usb_power
);

  // Control registers
  logic       w_ie_reg;
  logic       sl_ie_reg;
  logic       w_rst_reg;
  logic       sl_rst_reg;
  logic       eintena_reg;
  logic [7:0] w5300_cfg_reg;
  logic       ms_reg;

  // W5300 config fields
  logic [1:0] rom_win;
  logic       map_en;
  logic       a0_inv;
  logic       port_mode;
  logic [2:0] addr_hi;

  assign rom_win   = w5300_cfg_reg[1:0];
  assign map_en    = w5300_cfg_reg[2];
  assign a0_inv    = w5300_cfg_reg[3];
  assign port_mode = w5300_cfg_reg[4];
  assign addr_hi   = w5300_cfg_reg[7:5];

  // Address decode
  logic io_dec;
  logic sel_rstint;
  logic sel_w5300;
  logic sel_sl811;
  logic sel_sl_cmd;
  logic sel_data;
  logic sel_reg;
  logic mem_dec;
  logic sl_acc;
  logic w_acc;
  logic periph;

  assign io_dec     = ~ziorq_n && (za[7:0] == 8'hAB);
  assign sel_rstint = io_dec && (za[15:8] == 8'h83);
  assign sel_w5300  = io_dec && (za[15:8] == 8'h82);
  assign sel_sl811  = io_dec && (za[15:8] == 8'h81);
  assign sel_sl_cmd = io_dec && (za[15:8] == 8'h80);
  assign sel_data   = io_dec && ~za[15];
  assign sel_reg    = sel_rstint || sel_w5300 || sel_sl811;

  assign mem_dec = ~zmreq_n && ~zcsrom_n && map_en && (za[15:14] == rom_win);

  assign sl_acc = sel_sl_cmd || (sel_data && ~port_mode);
  assign w_acc  = mem_dec || (sel_data && port_mode);
  assign periph = sl_acc || w_acc;

  // Interrupt status
  logic w_irq;
  logic irq_any;

  assign w_irq   = ~w5300_int_n;
  assign irq_any = (w_irq && w_ie_reg) || (sl811_intrq && sl_ie_reg);

  // Register writes, sampled at the clock edge inside the I/O write cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ie_reg      <= 1'b0;
      sl_ie_reg     <= 1'b0;
      w_rst_reg     <= 1'b0;
      sl_rst_reg    <= 1'b0;
      eintena_reg   <= 1'b0;
      w5300_cfg_reg <= 8'h00;
      ms_reg        <= 1'b0;
    end else if (~zwr_n) begin
      if (sel_rstint) begin
        w_ie_reg    <= zd[2];
        sl_ie_reg   <= zd[3];
        w_rst_reg   <= zd[4];
        sl_rst_reg  <= zd[5];
        eintena_reg <= zd[6];
      end
      if (sel_w5300) begin
        w5300_cfg_reg <= zd;
      end
      if (sel_sl811) begin
        ms_reg <= zd[0];
      end
    end
  end

  // W5300 address: memory window remaps the top 8 KB of each 16 KB window
  // onto the W5300 register blocks; port mode uses addr_hi with za[14:8].
  logic [13:0] off;
  logic [9:0]  addr_raw;

  assign off = za[13:0];

  always_comb begin
    addr_raw = {addr_hi, za[14:8]};
    if (mem_dec) begin
      if (off[13] == 1'b0) begin
        addr_raw = off[9:0];
      end else if (off[12] == 1'b0) begin
        addr_raw = {1'b1, off[11:9], 5'b10111, off[0]};
      end else begin
        addr_raw = {1'b1, off[11:9], 5'b11000, off[0]};
      end
    end
  end

  assign w5300_addr = {addr_raw[9:1], addr_raw[0] ^ a0_inv};

  // Selects and strobes; everything is held inactive during reset
  logic rd_cyc;
  logic wr_cyc;

  assign rd_cyc = ~rst && ~zrd_n;
  // Read takes priority so a malformed cycle with both strobes low never
  // drives both data buses at once.
  assign wr_cyc = ~rst && ~zwr_n && zrd_n;

  assign ziorqge    = ~rst && (sel_reg || sel_sl_cmd || sel_data);
  assign zblkrom    = ~rst && mem_dec;
  assign w5300_cs_n = ~(~rst && w_acc);
  assign sl811_cs_n = ~(~rst && sl_acc);
  assign sl811_a0   = ~za[15];
  assign brd_n      = ~(periph && rd_cyc);
  assign bwr_n      = ~(periph && wr_cyc);

  assign w5300_rst_n = w_rst_reg;
  assign sl811_rst_n = sl_rst_reg;
  // A held-in-reset SL811 sees master mode; after release the stored bit.
  assign sl811_ms_n  = ~(ms_reg | ~sl_rst_reg);

  // Read data
  logic [7:0] reg_rdata;
  logic       zd_oe;

  always_comb begin
    reg_rdata = bd;
    if (sel_rstint) begin
      reg_rdata = {irq_any, eintena_reg, sl_rst_reg, w_rst_reg,
                   sl_ie_reg, w_ie_reg, sl811_intrq, w_irq};
    end else if (sel_w5300) begin
      reg_rdata = w5300_cfg_reg;
    end else if (sel_sl811) begin
      reg_rdata = {6'b000000, usb_power, ms_reg};
    end
  end

  assign zd_oe  = rd_cyc && (sel_reg || periph);
  assign zd     = zd_oe ? reg_rdata : 8'bzzzzzzzz;
  assign bd     = ~bwr_n ? zd : 8'bzzzzzzzz;
  assign zint_n = (eintena_reg && irq_any) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zxnet_bus_bridge.sv
// Directed testbench for zxnet_bus_bridge.
module tb_zxnet_bus_bridge;

  logic        clk;
  logic        rst;
  logic [15:0] za;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n;
  logic        w5300_int_n, sl811_intrq, usb_power;
  logic [7:0]  zd_drv, bd_drv;
  logic        zd_oe, bd_oe;
  wire  [7:0]  zd;
  wire  [7:0]  bd;
  wire         zint_n;
  logic        ziorqge, zblkrom, brd_n, bwr_n;
  logic        w5300_rst_n, w5300_cs_n;
  logic [9:0]  w5300_addr;
  logic        sl811_rst_n, sl811_a0, sl811_cs_n, sl811_ms_n;

  int checks;
  int failures;

  assign zd = zd_oe ? zd_drv : 8'bzzzzzzzz;
  assign bd = bd_oe ? bd_drv : 8'bzzzzzzzz;
  pullup (zint_n);

  zxnet_bus_bridge dut (
    .clk(clk), .rst(rst), .za(za), .zd(zd),
    .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
    .zcsrom_n(zcsrom_n), .ziorqge(ziorqge), .zblkrom(zblkrom), .zint_n(zint_n),
    .bd(bd), .brd_n(brd_n), .bwr_n(bwr_n),
    .w5300_rst_n(w5300_rst_n), .w5300_addr(w5300_addr), .w5300_cs_n(w5300_cs_n),
    .w5300_int_n(w5300_int_n), .sl811_rst_n(sl811_rst_n), .sl811_a0(sl811_a0),
    .sl811_cs_n(sl811_cs_n), .sl811_ms_n(sl811_ms_n), .sl811_intrq(sl811_intrq),
    .usb_power(usb_power)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_idle();
    ziorq_n = 1'b1; zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    zcsrom_n = 1'b1; zd_oe = 1'b0; bd_oe = 1'b0;
  endtask

  // Start an I/O read; checks follow, then bus_idle.
  task automatic io_rd(input logic [15:0] a);
    @(negedge clk);
    za = a; ziorq_n = 1'b0; zrd_n = 1'b0;
    #2;
  endtask

  // Start an I/O write; caller checks, then io_wr_end commits it.
  task automatic io_wr_begin(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    za = a; zd_drv = d; zd_oe = 1'b1; ziorq_n = 1'b0; zwr_n = 1'b0;
    #2;
  endtask

  task automatic io_wr_end();
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    io_wr_begin(a, d);
    io_wr_end();
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    za = a; zd_drv = d; zd_oe = 1'b1; zmreq_n = 1'b0; zcsrom_n = 1'b0; zwr_n = 1'b0;
    #2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    za = 16'h0000; zd_drv = 8'h00; bd_drv = 8'h00;
    w5300_int_n = 1'b1; sl811_intrq = 1'b0; usb_power = 1'b0;
    bus_idle();
    #1;
    // Decoded read while in reset must not produce strobes
    za = 16'h80AB; ziorq_n = 1'b0; zrd_n = 1'b0;
    #2;
    chk("rst_brd_n", {15'd0, brd_n}, 16'h0001);
    chk("rst_sl_cs_n", {15'd0, sl811_cs_n}, 16'h0001);
    bus_idle();
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    io_rd(16'h83AB);
    chk("rstint_reset_rd", {8'd0, zd}, 16'h0000);
    chk("rstint_ziorqge", {15'd0, ziorqge}, 16'h0001);
    chk("w5300_rst_n_reset", {15'd0, w5300_rst_n}, 16'h0000);
    chk("sl811_rst_n_reset", {15'd0, sl811_rst_n}, 16'h0000);
    chk("zint_n_reset", {15'd0, zint_n}, 16'h0001);
    chk("w5300_cs_n_reset", {15'd0, w5300_cs_n}, 16'h0001);
    bus_idle();

    // Release both chip resets
    io_wr(16'h83AB, 8'h30);
    chk("w5300_rst_n_rel", {15'd0, w5300_rst_n}, 16'h0001);
    chk("sl811_rst_n_rel", {15'd0, sl811_rst_n}, 16'h0001);

    // Interrupts: SL811 pending and enabled, eintena on
    sl811_intrq = 1'b1; w5300_int_n = 1'b1;
    io_wr(16'h83AB, 8'h78);
    io_rd(16'h83AB);
    chk("rstint_irq_rd", {8'd0, zd}, 16'h00FA);
    chk("zint_n_asserted", {15'd0, zint_n}, 16'h0000);
    bus_idle();
    io_wr(16'h83AB, 8'h34);
    io_rd(16'h83AB);
    chk("rstint_noirq_rd", {8'd0, zd}, 16'h0036);
    chk("zint_n_released", {15'd0, zint_n}, 16'h0001);
    bus_idle();
    // W5300 interrupt pending and enabled (bit2), eintena on
    w5300_int_n = 1'b0;
    io_wr(16'h83AB, 8'h74);
    io_rd(16'h83AB);
    chk("rstint_w_irq_rd", {8'd0, zd}, 16'h00F7);
    chk("zint_n_w_irq", {15'd0, zint_n}, 16'h0000);
    bus_idle();
    w5300_int_n = 1'b1;
    io_wr(16'h83AB, 8'h34);

    // Memory window 2, mapped
    io_wr(16'h82AB, 8'h06);
    mem_wr(16'h9800, 8'h5A);
    chk("mem_cs_n", {15'd0, w5300_cs_n}, 16'h0000);
    chk("mem_addr_low", {6'd0, w5300_addr}, 16'h0000);
    chk("mem_bd", {8'd0, bd}, 16'h005A);
    chk("mem_bwr_n", {15'd0, bwr_n}, 16'h0000);
    chk("mem_zblkrom", {15'd0, zblkrom}, 16'h0001);
    bus_idle();
    mem_wr(16'hA201, 8'h00);
    chk("mem_addr_2000", {6'd0, w5300_addr}, 16'h026F);
    bus_idle();
    // Window 0 mapped: the 0xA201 access is no longer ours
    io_wr(16'h82AB, 8'h04);
    mem_wr(16'hA201, 8'h00);
    chk("mem_win0_cs_n", {15'd0, w5300_cs_n}, 16'h0001);
    chk("mem_win0_zblkrom", {15'd0, zblkrom}, 16'h0000);
    chk("mem_win0_bwr_n", {15'd0, bwr_n}, 16'h0001);
    bus_idle();
    mem_wr(16'h1FFF, 8'h00);
    chk("mem_addr_1fff", {6'd0, w5300_addr}, 16'h03FF);
    bus_idle();
    mem_wr(16'h3601, 8'h00);
    chk("mem_addr_3000", {6'd0, w5300_addr}, 16'h02F1);
    bus_idle();

    // Port mode, addr_hi=5, a0 invert
    io_wr(16'h82AB, 8'hB8);
    bd_drv = 8'hC3; bd_oe = 1'b1;
    io_rd(16'h15AB);
    chk("port_w_cs_n", {15'd0, w5300_cs_n}, 16'h0000);
    chk("port_w_addr", {6'd0, w5300_addr}, 16'h0294);
    chk("port_brd_n", {15'd0, brd_n}, 16'h0000);
    chk("port_zd", {8'd0, zd}, 16'h00C3);
    chk("port_sl_cs_n", {15'd0, sl811_cs_n}, 16'h0001);
    bus_idle();
    io_rd(16'h82AB);
    chk("w5300_reg_rd", {8'd0, zd}, 16'h00B8);
    chk("reg_rd_brd_n", {15'd0, brd_n}, 16'h0001);
    bus_idle();

    // Port mode off: SL811 accesses
    io_wr(16'h82AB, 8'h00);
    io_wr_begin(16'h80AB, 8'h11);
    chk("sl_cmd_cs_n", {15'd0, sl811_cs_n}, 16'h0000);
    chk("sl_cmd_a0", {15'd0, sl811_a0}, 16'h0000);
    chk("sl_cmd_bd", {8'd0, bd}, 16'h0011);
    chk("sl_cmd_bwr_n", {15'd0, bwr_n}, 16'h0000);
    io_wr_end();
    bd_drv = 8'h77; bd_oe = 1'b1;
    io_rd(16'h42AB);
    chk("sl_data_a0", {15'd0, sl811_a0}, 16'h0001);
    chk("sl_data_cs_n", {15'd0, sl811_cs_n}, 16'h0000);
    chk("sl_data_zd", {8'd0, zd}, 16'h0077);
    chk("sl_data_w_cs_n", {15'd0, w5300_cs_n}, 16'h0001);
    bus_idle();

    // Undecoded port
    io_rd(16'h84AB);
    chk("undec_ziorqge", {15'd0, ziorqge}, 16'h0000);
    chk("undec_brd_n", {15'd0, brd_n}, 16'h0001);
    chk("undec_sl_cs_n", {15'd0, sl811_cs_n}, 16'h0001);
    bus_idle();

    // SL811 master/slave
    io_wr(16'h83AB, 8'h10);
    io_wr(16'h81AB, 8'h00);
    chk("ms_n_in_reset", {15'd0, sl811_ms_n}, 16'h0000);
    io_wr(16'h83AB, 8'h30);
    chk("ms_n_released", {15'd0, sl811_ms_n}, 16'h0001);
    io_wr(16'h81AB, 8'h01);
    chk("ms_n_ms1", {15'd0, sl811_ms_n}, 16'h0000);
    usb_power = 1'b1;
    io_rd(16'h81AB);
    chk("sl811_reg_rd", {8'd0, zd}, 16'h0003);
    bus_idle();

    // Asynchronous reset, mid-cycle away from the clock edge
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_w_rst_n", {15'd0, w5300_rst_n}, 16'h0000);
    chk("async_sl_rst_n", {15'd0, sl811_rst_n}, 16'h0000);
    chk("async_ms_n", {15'd0, sl811_ms_n}, 16'h0000);
    rst = 1'b0;
    io_rd(16'h82AB);
    chk("async_w_reg_rd", {8'd0, zd}, 16'h0000);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
